seq_alu: RTL and testbench

//   Multi-cycle, parametrised calculator ALU: add, sub, mul, div, power on unsigned operands.

---
 rtl/seq_alu_if.sv | 28 ++
 rtl/seq_alu.sv | 234 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the operand capture logic and seq_alu.
// master drives the request; slave (the ALU) drives status and results.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned OUT_W = 14
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] out;
    logic [WIDTH-1:0] rem;
    logic             neg;
    logic             ovf;
    logic             err;

    modport master (
        output start, op, a, b,
        input  busy, done, out, rem, neg, ovf, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, out, rem, neg, ovf, err
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle unsigned add/sub/mul/div/pow ALU with start/busy/done handshake.
// Define SEQ_ALU_SAT_EN to saturate overflowed results; otherwise they wrap mod 2^OUT_W.
module seq_alu #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned OUT_W = 14
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam int unsigned PW = OUT_W + WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpDiv = 3'b011;
    localparam logic [2:0] OpPow = 3'b100;

`ifdef SEQ_ALU_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StAddSub, StMul, StDiv, StPow, StDone} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             fin_q, fin_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [PW-1:0]    prod_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   sum_ab;
    logic             mul_ovf;
    logic             pow_ovf;

    // Shared shift-add step: mul uses (a, b), pow uses (acc, a) as multiplicand/multiplier.
    assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign trial    = {part_q, quo_q[WIDTH-1]};
    assign sum_ab   = {1'b0, a_q} + {1'b0, b_q};
    assign mul_ovf  = (prod_q >> OUT_W) != '0;
    assign pow_ovf  = (prod_sum >> OUT_W) != '0;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        quo_d    = quo_q;
        part_d   = part_q;
        acc_d    = acc_q;
        fin_d    = fin_q;
        out_d    = out_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    neg_d    = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    prod_d   = '0;
                    fin_d    = 1'b0;
                    part_d   = '0;
                    quo_d    = bus.a;
                    acc_d    = OUT_W'(1);
                    mcand_d  = PW'(1);
                    mplier_d = bus.a;
                    unique case (bus.op)
                        OpMul: begin
                            state_d  = StMul;
                            mcand_d  = PW'(bus.a);
                            mplier_d = bus.b;
                        end
                        OpDiv: state_d = (bus.b == '0) ? StAddSub : StDiv;
                        // 0^b, 1^b and x^0 need no multiplies
                        OpPow: state_d = (bus.b == '0 || bus.a <= WIDTH'(1)) ? StAddSub : StPow;
                        default: state_d = StAddSub;
                    endcase
                end
            end
            StAddSub: begin
                state_d = StDone;
                out_d   = '0;
                rem_d   = '0;
                unique case (op_q)
                    OpAdd: out_d = OUT_W'(sum_ab);
                    OpSub: begin
                        if (a_q >= b_q) begin
                            out_d = OUT_W'(a_q - b_q);
                        end else begin
                            out_d = OUT_W'(b_q - a_q);
                            neg_d = 1'b1;
                        end
                    end
                    OpDiv: begin
                        out_d = '1;
                        err_d = 1'b1;
                    end
                    OpPow: out_d = (b_q == '0) ? OUT_W'(1) : OUT_W'(a_q);
                    default: err_d = 1'b1;
                endcase
            end
            StMul: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = StDone;
                    ovf_d   = mul_ovf;
                    out_d   = (SatEn && mul_ovf) ? '1 : prod_q[OUT_W-1:0];
                    rem_d   = '0;
                end else begin
                    prod_d   = prod_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            StDiv: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = StDone;
                    out_d   = OUT_W'(quo_q);
                    rem_d   = part_q;
                end else begin
                    if (trial >= {1'b0, b_q}) begin
                        part_d = WIDTH'(trial - {1'b0, b_q});
                        quo_d  = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        part_d = trial[WIDTH-1:0];
                        quo_d  = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StPow: begin
                if (fin_q) begin
                    state_d = StDone;
                    out_d   = (SatEn && ovf_q) ? '1 : acc_q;
                    rem_d   = '0;
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit of this multiply: commit acc, b_q counts remaining multiplies
                    acc_d    = prod_sum[OUT_W-1:0];
                    ovf_d    = pow_ovf;
                    fin_d    = pow_ovf || (b_q == WIDTH'(1));
                    b_d      = b_q - WIDTH'(1);
                    prod_d   = '0;
                    mcand_d  = PW'(prod_sum[OUT_W-1:0]);
                    mplier_d = a_q;
                    cnt_d    = '0;
                end else begin
                    prod_d   = prod_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            part_q   <= '0;
            acc_q    <= '0;
            fin_q    <= 1'b0;
            out_q    <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            quo_q    <= quo_d;
            part_q   <= part_d;
            acc_q    <= acc_d;
            fin_q    <= fin_d;
            out_q    <= out_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy = (state_q == StAddSub) || (state_q == StMul) ||
                      (state_q == StDiv) || (state_q == StPow);
    assign bus.done = (state_q == StDone);
    assign bus.out  = out_q;
    assign bus.rem  = rem_q;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, handshake corner cases,
// and random operations checked against an arithmetic reference model.
module tb_seq_alu;
    localparam int W  = 10;
    localparam int OW = 14;
    localparam longint MAXV = (64'd1 << OW) - 1;

`ifdef SEQ_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint out;
        longint rem;
        bit     neg;
        bit     ovf;
        bit     err;
        int     lat;
    } res_t;

    typedef struct {
        logic [2:0] op;
        int         a;
        int         b;
        res_t       exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_alu_if #(.WIDTH(W), .OUT_W(OW)) bus ();

    seq_alu #(.WIDTH(W), .OUT_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic res_t model(input int op, input longint a, input longint b);
        res_t r;
        longint acc;
        int k;
        r = '{out: 0, rem: 0, neg: 0, ovf: 0, err: 0, lat: 1};
        case (op)
            0: r.out = a + b;
            1: begin
                r.neg = (a < b);
                r.out = r.neg ? b - a : a - b;
            end
            2: begin
                acc   = a * b;
                r.ovf = acc > MAXV;
                r.out = (r.ovf && SAT) ? MAXV : acc % (MAXV + 1);
                r.lat = W + 1;
            end
            3: begin
                if (b == 0) begin
                    r.out = MAXV;
                    r.err = 1;
                end else begin
                    r.out = a / b;
                    r.rem = a % b;
                    r.lat = W + 1;
                end
            end
            4: begin
                if (b == 0) r.out = 1;
                else if (a <= 1) r.out = a;
                else begin
                    acc = 1;
                    k   = 0;
                    for (longint i = 0; i < b; i++) begin
                        acc = acc * a;
                        k++;
                        if (acc > MAXV) begin
                            r.ovf = 1;
                            break;
                        end
                    end
                    r.out = (r.ovf && SAT) ? MAXV : acc % (MAXV + 1);
                    r.lat = 1 + W * k;
                end
            end
            default: r.err = 1;
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input int a, input int b, input longint o,
                                input longint rm, input bit ng, input bit ov, input bit er,
                                input int lat);
        vec_t v;
        v.op  = op;
        v.a   = a;
        v.b   = b;
        v.exp = '{out: o, rem: rm, neg: ng, ovf: ov, err: er, lat: lat};
        return v;
    endfunction

    task automatic wait_done(output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = c;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input int a, input int b,
                          output int lat, output bit to);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = W'(a);
        bus.b     = W'(b);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("accept.busy", bus.busy, 1);
        wait_done(lat, to);
    endtask

    task automatic check_result(input string tag, input res_t e, input int lat, input bit to);
        check({tag, ".timeout"}, longint'(to), 0);
        check({tag, ".latency"}, lat, e.lat);
        check({tag, ".out"}, bus.out, e.out);
        check({tag, ".rem"}, bus.rem, e.rem);
        check({tag, ".neg"}, bus.neg, e.neg);
        check({tag, ".ovf"}, bus.ovf, e.ovf);
        check({tag, ".err"}, bus.err, e.err);
        check({tag, ".busy_at_done"}, bus.busy, 0);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, bus.done, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, bus.busy, 0);
        check({tag, ".done"}, bus.done, 0);
        check({tag, ".out"}, bus.out, 0);
        check({tag, ".rem"}, bus.rem, 0);
        check({tag, ".flags"}, {bus.neg, bus.ovf, bus.err}, 0);
    endtask

    initial begin
        vec_t vecs[16];
        int   lat;
        bit   to;
        int   done_seen;
        int   op;
        int   a;
        int   b;
        res_t e;

        vecs[0]  = mk(3'b000, 1, 17, 18, 0, 0, 0, 0, 1);
        vecs[1]  = mk(3'b001, 31, 11, 20, 0, 0, 0, 0, 1);
        vecs[2]  = mk(3'b001, 11, 31, 20, 0, 1, 0, 0, 1);
        vecs[3]  = mk(3'b010, 1006, 463, SAT ? 16383 : 7026, 0, 0, 1, 0, W + 1);
        vecs[4]  = mk(3'b011, 11, 17, 0, 11, 0, 0, 0, W + 1);
        vecs[5]  = mk(3'b011, 1000, 7, 142, 6, 0, 0, 0, W + 1);
        vecs[6]  = mk(3'b011, 5, 0, 16383, 0, 0, 0, 1, 1);
        vecs[7]  = mk(3'b100, 9, 3, 729, 0, 0, 0, 0, 31);
        vecs[8]  = mk(3'b100, 14, 18, SAT ? 16383 : 5648, 0, 0, 1, 0, 1 + W * 4);
        vecs[9]  = mk(3'b100, 7, 0, 1, 0, 0, 0, 0, 1);
        vecs[10] = mk(3'b110, 100, 3, 0, 0, 0, 0, 1, 1);
        vecs[11] = mk(3'b100, 0, 0, 1, 0, 0, 0, 0, 1);
        vecs[12] = mk(3'b100, 1, 500, 1, 0, 0, 0, 0, 1);
        vecs[13] = mk(3'b000, 1023, 1023, 2046, 0, 0, 0, 0, 1);
        vecs[14] = mk(3'b001, 5, 5, 0, 0, 0, 0, 0, 1);
        vecs[15] = mk(3'b010, 127, 129, 16383, 0, 0, 0, 0, W + 1);

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, to);
            check_result($sformatf("vec%0d", i), vecs[i].exp, lat, to);
        end

        // Start held high while busy and through the done cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.a     = W'(1000);
        bus.b     = W'(7);
        @(posedge clk);
        #1;
        bus.op = 3'b000;
        bus.a  = W'(1);
        bus.b  = W'(2);
        wait_done(lat, to);
        check("busy_start.timeout", longint'(to), 0);
        check("busy_start.latency", lat, W + 1);
        check("busy_start.out", bus.out, 142);
        check("busy_start.rem", bus.rem, 6);
        @(posedge clk);
        #1;
        check("done_start.ignored", bus.busy, 0);
        @(posedge clk);
        #1;
        check("after_done.accepted", bus.busy, 1);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("after_done.done", bus.done, 1);
        check("after_done.out", bus.out, 3);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.a     = W'(1006);
        bus.b     = W'(463);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst       = 1'b0;
        done_seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_seen++;
        end
        check("rst_mid.no_done", done_seen, 0);
        check("rst_mid.idle", bus.busy, 0);

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, (1 << W) - 1);
            b  = $urandom_range(0, (1 << W) - 1);
            if (op == 4 && $urandom_range(0, 1) == 1) b = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 2);
            if (op == 3 && $urandom_range(0, 7) == 0) b = 0;
            e = model(op, a, b);
            run_op(3'(op), a, b, lat, to);
            check_result($sformatf("rnd%0d_op%0d_a%0d_b%0d", i, op, a, b), e, lat, to);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
